// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger controller: fires a trigger pulse, times the echo
// high width in clocks, and enforces a hold-off gap between measurements.
module hcsr04_ranger #(
    parameter int TRIG_CYCLES    = 640,
    parameter int TIMEOUT_CYCLES = 2560000,
    parameter int HOLDOFF_CYCLES = 3840000,
    parameter int CNT_W          = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_echo,
    output logic             o_trigger,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_echo_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALL_ONES     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             echoMeta_q, echoS_q, echoPrev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             echoRise, echoFall, timeUp;

    assign echoRise = echoS_q & ~echoPrev_q;
    assign echoFall = ~echoS_q & echoPrev_q;
    // cnt_q doubles as the trigger, timeout and hold-off counter; only one runs at a time
    assign timeUp   = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            echoMeta_q <= 1'b0;
            echoS_q    <= 1'b0;
            echoPrev_q <= 1'b0;
            cnt_q      <= '0;
            width_q    <= '0;
            cycles_q   <= '0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            echoMeta_q <= i_echo;
            echoS_q    <= echoMeta_q;
            echoPrev_q <= echoS_q;
            cnt_q      <= cnt_d;
            width_q    <= width_d;
            cycles_q   <= cycles_d;
            trigger_q  <= trigger_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        cycles_d  = cycles_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RISE: begin
                cnt_d = cnt_q + 1'b1;
                if (timeUp) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    cycles_d  = ALL_ONES;
                end else if (echoRise) begin
                    state_d = MEASURE;
                    width_d = CNT_W'(1);
                end
            end
            MEASURE: begin
                cnt_d = cnt_q + 1'b1;
                // A falling edge on the final counted cycle still yields a valid width
                if (echoFall) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    cycles_d  = width_q;
                end else if (timeUp) begin
                    state_d   = HOLDOFF;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    cycles_d  = ALL_ONES;
                end else if (echoS_q && (width_q != ALL_ONES)) begin
                    width_d = width_q + 1'b1;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        trigger_d = (state_d == TRIG);
        busy_d    = (state_d != IDLE);
    end

    assign o_trigger     = trigger_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_timeout     = timeout_q;
    assign o_echo_cycles = cycles_q;

endmodule
